// File: rtl/mem_access_unit.sv
// mem_access_unit: sits between the control FSM and a single-port RAM with
// synchronous read and synchronous write. It services one request at a time:
// an instruction fetch into ir_out, or a data load/store.
// Byte and halfword lanes are little-endian. Word loads from unaligned
// addresses are rotated, and byte/halfword loads can be sign-extended.
// The RAM has only one word-wide write enable, so byte and halfword stores
// are done as read-modify-write.
module mem_access_unit #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_fetch,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              abort,
    output logic [31:0]       rdata,
    output logic [31:0]       ir_out,
    output logic              ir_load,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_WR, S_RMW_RD, S_RMW_CAP
    } state_t;

    state_t              state_q, state_d;
    logic [RAM_AW+1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                fetch_q, fetch_d;
    logic [31:0]         data_q, data_d;      // store data, later the merged RMW word
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                ir_load_q, ir_load_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         ir_q, ir_d;

    // Address bits above the RAM range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:RAM_AW+2];

    // Lane extraction for loads. Word loads rotate right by 8*addr[1:0].
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00: r = {{24{sg & b[7]}}, b};
            2'b01: r = {{16{sg & h[15]}}, h};
            default: begin
                case (a)
                    2'd0:    r = w;
                    2'd1:    r = {w[7:0],  w[31:8]};
                    2'd2:    r = {w[15:0], w[31:16]};
                    default: r = {w[23:0], w[31:24]};
                endcase
            end
        endcase
        return r;
    endfunction

    // Replace one byte or halfword lane of the old RAM word with new store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = old;
        if (sz == 2'b00) begin
            case (a)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (a[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        return r;
    endfunction

    // State and output registers. The async reset also drops ram_we at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            fetch_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            ir_load_q <= 1'b0;
            rdata_q   <= '0;
            ir_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            fetch_q   <= fetch_d;
            data_q    <= data_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            ir_load_q <= ir_load_d;
            rdata_q   <= rdata_d;
            ir_q      <= ir_d;
        end
    end

    // Next-state logic: dispatch on accept, sequence the RAM and format the result.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        fetch_d   = fetch_q;
        data_d    = data_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        ir_load_d = 1'b0;
        rdata_d   = rdata_q;
        ir_d      = ir_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[RAM_AW+1:0];
                    size_d   = req_size;
                    signed_d = req_signed;
                    fetch_d  = req_fetch;
                    data_d   = req_wdata;
                    if (!req_fetch && req_size == 2'b01 && req_addr[0]) begin
                        abort_d = 1'b1;                // misaligned halfword: no RAM access
                    end else if (req_fetch || !req_we) begin
                        state_d = S_RD;
                    end else if (req_size[1]) begin
                        state_d = S_WR;                // word (or reserved size) store
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                if (fetch_q) begin
                    ir_d      = ram_rdata;
                    ir_load_d = 1'b1;
                end else begin
                    rdata_d = fmt_load(ram_rdata, addr_q[1:0], size_q, signed_q);
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_RMW_RD:  state_d = S_RMW_CAP;
            S_RMW_CAP: begin
                data_d  = merge_lane(ram_rdata, data_q, addr_q[1:0], size_q);
                state_d = S_WR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign ram_en    = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_RMW_RD);
    assign ram_we    = (state_q == S_WR);
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = data_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign ir_load   = ir_load_q;
    assign rdata     = rdata_q;
    assign ir_out    = ir_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests with hand-computed results,
// a behavioural sync RAM, and a scoreboard checked by a separate monitor.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic        req_fetch = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        done, abort, ir_load, ram_en, ram_we;
    logic [31:0] rdata, ir_out, ram_wdata, ram_rdata;
    logic [9:0]  ram_addr;

    mem_access_unit #(.RAM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fetch(req_fetch), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .abort(abort), .rdata(rdata), .ir_out(ir_out), .ir_load(ir_load),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: sync write, sync read.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    bit track_we = 1'b0;
    bit we_seen = 1'b0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // kind: 0 = done, 1 = done with ir_load, 2 = abort
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] rd;
        logic [31:0] ir;
    } exp_t;
    exp_t q[$];

    logic [31:0] er = '0;   // rdata expected to be on the output after each completion
    logic [31:0] ei = '0;   // ir_out expected likewise

    // Monitor: pop and compare whenever the DUT signals completion.
    always @(negedge clk) begin
        if (ram_en) en_cnt++;
        if (track_we && ram_we) we_seen = 1'b1;
        if (done || abort) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got done=%0b abort=%0b expected none", done, abort);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("txn kind=%0d cyc=%0d rdata=%h ir_out=%h", e.kind, cyc, rdata, ir_out);
                chk("done", {31'b0, done}, {31'b0, e.kind != 2});
                chk("abort", {31'b0, abort}, {31'b0, e.kind == 2});
                chk("ir_load", {31'b0, ir_load}, {31'b0, e.kind == 1});
                chk("latency_cycle", cyc, e.cyc);
                chk("rdata", rdata, e.rd);
                chk("ir_out", ir_out, e.ir);
            end
        end
    end

    // Present one request, wait for acceptance, push its expected response.
    task automatic issue(input logic f, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int kind, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_fetch = f; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) q.push_back('{kind, cyc + lat, er, ei});
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        issue(1'b0, 1'b1, sz, 1'b0, a, wd, 0, sz[1] ? 1 : 3, 1'b1);
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] exp);
        er = exp;
        issue(1'b0, 1'b0, sz, sg, a, 32'h0, 0, 2, 1'b1);
    endtask

    task automatic fetch(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] exp);
        ei = exp;
        issue(1'b1, we, sz, 1'b0, a, 32'hFFFF_FFFF, 1, 2, 1'b1);
    endtask

    task automatic bad_half(input logic we, input logic [31:0] a);
        issue(1'b0, we, 2'b01, 1'b1, a, 32'h0000_1234, 2, 0, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    int en_before;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_abort", {31'b0, abort}, 32'd0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ir_out", ir_out, 32'd0);
        rst = 1'b1;

        // Word store then word load, back to back.
        st(2'b10, 32'h100, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        st(2'b10, 32'h100, 32'h11223344);
        ld(2'b10, 1'b0, 32'h101, 32'h44112233);          // rotate right 8
        st(2'b00, 32'h101, 32'hABCDEF80);                // only low byte used
        wait_idle();
        chk("mem_byte_rmw", mem[10'h40], 32'h11228044);
        ld(2'b00, 1'b1, 32'h101, 32'hFFFFFF80);
        ld(2'b00, 1'b0, 32'h101, 32'h00000080);
        ld(2'b01, 1'b1, 32'h100, 32'hFFFF8044);
        ld(2'b01, 1'b1, 32'h102, 32'h00001122);
        st(2'b01, 32'h102, 32'h1234BEEF);                // -> BEEF8044
        st(2'b00, 32'h103, 32'h0000005A);                // -> 5AEF8044
        ld(2'b10, 1'b0, 32'h103, 32'hEF80445A);          // rotate right 24
        wait_idle();
        chk("mem_half_byte", mem[10'h40], 32'h5AEF8044);

        // Misaligned halfwords abort with no RAM access and rdata held.
        en_before = en_cnt;
        bad_half(1'b0, 32'h103);
        bad_half(1'b1, 32'h101);
        wait_idle();
        chk("abort_no_ram_en", en_cnt, en_before);
        chk("abort_mem_kept", mem[10'h40], 32'h5AEF8044);

        // Fetches: addr[1:0] ignored, we/size overridden, rdata untouched.
        st(2'b10, 32'h100, 32'hE3A01005);
        fetch(1'b0, 2'b10, 32'h102, 32'hE3A01005);
        st(2'b10, 32'h104, 32'hE1A00000);
        fetch(1'b1, 2'b01, 32'h107, 32'hE1A00000);
        ld(2'b10, 1'b0, 32'h100, 32'hE3A01005);
        // Reserved size acts as word; upper address bits ignored.
        st(2'b11, 32'h10000FFC, 32'hCAFEF00D);
        ld(2'b11, 1'b0, 32'h00000FFC, 32'hCAFEF00D);
        wait_idle();
        chk("fetch_no_write", mem[10'h41], 32'hE1A00000);
        chk("mem_top_word", mem[10'h3FF], 32'hCAFEF00D);

        // Reset during RMW_CAP of a byte store: nothing written, outputs cleared.
        st(2'b10, 32'h200, 32'h11223344);
        wait_idle();
        track_we = 1'b1;
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AA, 0, 3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_mid_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_ir_out", ir_out, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_we_seen", {31'b0, we_seen}, 32'd0);
        chk("rst_mid_mem", mem[10'h80], 32'h11223344);
        track_we = 1'b0;
        er = '0;
        ei = '0;
        ld(2'b10, 1'b0, 32'h201, 32'h44112233);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
